// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
// seg7_pkg: shared 7-segment definitions for the display driver and the
// capture decoder. Segment bit order is bit 0 = a ... bit 6 = g, bit 7 = dp.
// Contents: segment bit indices, blank pattern, the 16 hex glyphs (indexed
// by digit value) and the capture filter state type.
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Index i holds the glyph for hex digit i.
    localparam logic [6:0] SEG_GLYPHS [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3,
        GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B,
        GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };

    typedef enum logic {
        SETTLE = 1'b0,
        STABLE = 1'b1
    } filter_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
`timescale 1ns/1ps
// seg7_pattern_decode: combinational reverse lookup of a 7-segment pattern.
// Ports:
//   pattern  in  7  active-high segments, bit 0 = a ... bit 6 = g
//   hex      out 4  matching digit, 0 when blank or invalid
//   blank    out 1  pattern is all-off
//   invalid  out 1  pattern is neither a glyph nor blank
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        hex     = '0;
        blank   = 1'b0;
        invalid = 1'b0;
        if (pattern == SEG_BLANK) begin
            blank = 1'b1;
        end else begin
            invalid = 1'b1;
            for (int unsigned i = 0; i < 16; i++) begin
                if (pattern == SEG_GLYPHS[i]) begin
                    hex     = 4'(i);
                    invalid = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
`timescale 1ns/1ps
// seg7_capture_decoder: samples a one-digit 7-segment bus, waits for the
// pattern to hold for STABLE_CYCLES synchronized samples, decodes it and
// offers each new stable value on a valid/ready handshake.
// Parameters:
//   STABLE_CYCLES  equal samples needed for a stable pattern (2..65535)
//   COMMON_ANODE   1 inverts the synchronized bus to active-high
// Ports:
//   clk50MHz  in   clock
//   rst_n     in   asynchronous active-low reset
//   Segments  in 7 segment bus (a = bit 0), dp in 1 decimal point
//   hex_out   out 4 decoded digit;  dp_out out 1 captured dp
//   blank     out  captured pattern was all-off
//   invalid   out  captured pattern not a glyph and not blank
//   valid     out  word held for the consumer;  ready in  consumer accepts
//   overrun   out  sticky: a stable unreported pattern was lost
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          COMMON_ANODE  = 1'b0
) (
    input  logic       clk50MHz,
    input  logic       rst_n,
    input  logic [6:0] Segments,
    input  logic       dp,
    output logic [3:0] hex_out,
    output logic       dp_out,
    output logic       blank,
    output logic       invalid,
    output logic       valid,
    input  logic       ready,
    output logic       overrun
);

    localparam int unsigned     CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    s2v;
    logic [7:0]    prev;
    logic [7:0]    last_rep;
    logic [CW-1:0] cnt;
    filter_state_t state;

    logic          changed;
    logic          pending;
    logic          load;
    logic [3:0]    dec_hex;
    logic          dec_blank;
    logic          dec_invalid;

    assign s2v     = COMMON_ANODE ? ~s2 : s2;
    assign changed = (s2v != prev);
    assign pending = (state == STABLE) && (prev != last_rep);
    assign load    = pending && (!valid || ready);

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {dp, Segments};
            s2 <= s1;
        end
    end

    // state is registered alongside cnt so that it reads STABLE exactly
    // when cnt sits at CNT_MAX.
    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            cnt   <= '0;
            state <= SETTLE;
        end else if (changed) begin
            prev  <= s2v;
            cnt   <= '0;
            state <= SETTLE;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            state <= (cnt >= CNT_MAX - CW'(1)) ? STABLE : SETTLE;
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (prev[6:0]),
        .hex     (dec_hex),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            hex_out  <= '0;
            dp_out   <= 1'b0;
            blank    <= 1'b0;
            invalid  <= 1'b0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            last_rep <= '0;
        end else begin
            if (load) begin
                hex_out  <= dec_hex;
                dp_out   <= prev[SEG_DP];
                blank    <= dec_blank;
                invalid  <= dec_invalid;
                valid    <= 1'b1;
                last_rep <= prev;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            // A stable pattern still waiting for the consumer is replaced.
            if (pending && valid && !ready && changed) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
`timescale 1ns/1ps
module tb_seg7_capture_decoder;

    localparam int unsigned SC   = 4;
    localparam int          HLEN = SC + 2;

    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk50MHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic [6:0] Segments = '0;
    logic       dp       = 1'b0;
    logic       ready    = 1'b1;

    logic [3:0] hex0, hex1;
    logic       dp0, dp1, bl0, bl1, inv0, inv1, v0, v1, ov0, ov1;

    int checks = 0;
    int errors = 0;

    always #10 clk50MHz = ~clk50MHz;

    seg7_capture_decoder #(.STABLE_CYCLES(SC), .COMMON_ANODE(1'b0)) dut (
        .clk50MHz (clk50MHz), .rst_n (rst_n), .Segments (Segments), .dp (dp),
        .hex_out (hex0), .dp_out (dp0), .blank (bl0), .invalid (inv0),
        .valid (v0), .ready (ready), .overrun (ov0)
    );

    seg7_capture_decoder #(.STABLE_CYCLES(SC), .COMMON_ANODE(1'b1)) dut_ca (
        .clk50MHz (clk50MHz), .rst_n (rst_n), .Segments (Segments), .dp (dp),
        .hex_out (hex1), .dp_out (dp1), .blank (bl1), .invalid (inv1),
        .valid (v1), .ready (ready), .overrun (ov1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: history of the pattern seen after synchronization and
    // optional inversion, newest first: [0]=s1 view, [1]=s2 view, [2..]=filter.
    // A pattern is stable when the SC newest filtered samples all agree.
    int         mh [2][HLEN];
    bit         mv [2];
    bit         mo [2];
    int         mlast [2];
    logic [6:0] mw [2];     // {dp, blank, invalid, hex}

    function automatic logic [6:0] mdecode(input logic [7:0] p);
        logic [3:0] h;
        bit         found;
        h = 4'h0;
        found = 1'b0;
        if (p[6:0] == 7'h00) return {p[7], 1'b1, 1'b0, 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (GLY[i] == p[6:0]) begin
                h = i[3:0];
                found = 1'b1;
            end
        end
        return found ? {p[7], 2'b00, h} : {p[7], 1'b0, 1'b1, 4'h0};
    endfunction

    function automatic int seen(input int c, input logic [7:0] raw);
        logic [7:0] v;
        v = (c != 0) ? ~raw : raw;
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mh[c][0] = seen(c, 8'h00);
            mh[c][1] = seen(c, 8'h00);
            mh[c][2] = 0;
            for (int j = 3; j < HLEN; j++) mh[c][j] = -j;
            mv[c] = 1'b0;
            mo[c] = 1'b0;
            mlast[c] = 0;
            mw[c] = '0;
        end
    endtask

    task automatic model_step(input int c);
        bit stable;
        bit pend;
        bit ld;
        stable = 1'b1;
        for (int j = 3; j < HLEN; j++) if (mh[c][j] != mh[c][2]) stable = 1'b0;
        pend = stable && (mh[c][2] != mlast[c]);
        ld   = pend && (!mv[c] || ready);
        if (pend && mv[c] && !ready && (mh[c][1] != mh[c][2])) mo[c] = 1'b1;
        if (ld) begin
            mw[c] = mdecode(8'(mh[c][2]));
            mv[c] = 1'b1;
            mlast[c] = mh[c][2];
        end else if (mv[c] && ready) begin
            mv[c] = 1'b0;
        end
        for (int j = HLEN - 1; j > 0; j--) mh[c][j] = mh[c][j-1];
        mh[c][0] = seen(c, {dp, Segments});
    endtask

    always @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk50MHz) begin
        check("out_inst0", 32'({ov0, v0, dp0, bl0, inv0, hex0}), 32'({mo[0], mv[0], mw[0]}));
        check("out_inst1", 32'({ov1, v1, dp1, bl1, inv1, hex1}), 32'({mo[1], mv[1], mw[1]}));
    end

    // Transferred words, {dp, blank, invalid, hex}
    logic [6:0] log0 [$];
    logic [6:0] log1 [$];

    always @(posedge clk50MHz) begin
        if (rst_n && v0 && ready) log0.push_back({dp0, bl0, inv0, hex0});
        if (rst_n && v1 && ready) log1.push_back({dp1, bl1, inv1, hex1});
    end

    task automatic hold(input logic [6:0] seg, input logic d, input int n);
        Segments = seg;
        dp = d;
        repeat (n) @(negedge clk50MHz);
    endtask

    initial begin
        int         r;
        logic [6:0] p;

        rst_n = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk50MHz);
        check("reset_outputs", 32'({ov0, v0, dp0, bl0, inv0, hex0}), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk50MHz);
        check("blank_not_reported", 32'(log0.size()), 32'd0);

        // Single digit 3: valid pulses after the 7th edge
        Segments = 7'h4F;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk50MHz);
            check("t1_not_yet_valid", 32'(v0), 32'd0);
        end
        @(negedge clk50MHz);
        check("t1_valid_edge7", 32'(v0), 32'd1);
        check("t1_word", 32'({dp0, bl0, inv0, hex0}), 32'h03);
        check("t1_model_word", 32'(mw[0]), 32'h03);
        @(negedge clk50MHz);
        check("t1_pulse_end", 32'(v0), 32'd0);
        repeat (20) @(negedge clk50MHz);
        check("t1_reported_once", 32'(log0.size()), 32'd1);

        // All 16 glyphs in order, dp alternating
        log0.delete();
        for (int i = 0; i < 16; i++) hold(GLY[i], i[0], 10);
        check("t2_count", 32'(log0.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < log0.size()) check("t2_word", 32'(log0[i]), 32'({i[0], 2'b00, i[3:0]}));

        // Glitch of 3 samples is ignored
        log0.delete();
        hold(7'h7F, 1'b0, 10);
        hold(7'h06, 1'b0, 3);
        hold(7'h7F, 1'b0, 15);
        check("t3_count", 32'(log0.size()), 32'd1);
        if (log0.size() > 0) check("t3_word", 32'(log0[0]), 32'h08);
        check("t3_no_overrun", 32'(ov0), 32'd0);

        // Consumer stalled: 1 held, 2 lost, 3 delivered after
        ready = 1'b0;
        log0.delete();
        hold(7'h06, 1'b0, 10);
        hold(7'h5B, 1'b0, 10);
        hold(7'h4F, 1'b0, 10);
        check("t4_held_word", 32'({v0, hex0}), 32'h11);
        check("t4_overrun", 32'(ov0), 32'd1);
        ready = 1'b1;
        repeat (12) @(negedge clk50MHz);
        check("t4_count", 32'(log0.size()), 32'd2);
        if (log0.size() > 1) begin
            check("t4_first", 32'(log0[0]), 32'h01);
            check("t4_second", 32'(log0[1]), 32'h03);
        end

        // Blank and invalid patterns
        log0.delete();
        hold(7'h00, 1'b0, 10);
        hold(7'h55, 1'b0, 10);
        check("t5_count", 32'(log0.size()), 32'd2);
        if (log0.size() > 1) begin
            check("t5_blank", 32'(log0[0]), 32'h20);
            check("t5_invalid", 32'(log0[1]), 32'h10);
        end

        // Common-anode: raw g-only with dp high reads as digit 0, dp 0
        log1.delete();
        hold(7'h40, 1'b1, 10);
        check("t6_ca_count", 32'(log1.size()), 32'd1);
        if (log1.size() > 0) check("t6_ca_word", 32'(log1[0]), 32'h00);

        // Reset while a word is held
        ready = 1'b0;
        hold(7'h6D, 1'b0, 10);
        check("t7_held", 32'({v0, hex0}), 32'h15);
        #5 rst_n = 1'b0;
        #1 check("t7_async_reset", 32'({ov0, v0, dp0, bl0, inv0, hex0}), 32'h0);
        @(negedge clk50MHz);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk50MHz);
            check("t7_not_yet_valid", 32'(v0), 32'd0);
        end
        @(negedge clk50MHz);
        check("t7_rereported", 32'({ov0, v0, hex0}), 32'h15);

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       p = GLY[$urandom_range(0, 15)];
            else if (r == 6) p = 7'h00;
            else             p = 7'($urandom);
            Segments = p;
            dp = 1'($urandom);
            repeat ($urandom_range(1, 12)) begin
                ready = 1'($urandom);
                @(negedge clk50MHz);
            end
        end
        ready = 1'b1;
        repeat (20) @(negedge clk50MHz);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
